sseg_scan_mux: RTL

//  Parametrised N-digit multiplexed seven-segment display driver; next generation of the fixed 4-digit counter+sseg4 pair.

---
 rtl/sseg_scan_mux.sv | 120 ++++++++++++
 1 files changed

// File: rtl/sseg_scan_mux.sv
// N-digit multiplexed seven-segment driver with its own refresh prescaler,
// tear-free snapshot, per-digit blank/decimal point and PWM brightness.
module sseg_scan_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int DIV_BITS    = 17,
  parameter int BRIGHT_BITS = 4,
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    load,
  input  logic [BRIGHT_BITS-1:0]  brightness,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IDX_W-1:0]        digit_idx
);

  logic [DIV_BITS-1:0]     p;
  logic [4*NUM_DIGITS-1:0] data_s;
  logic [NUM_DIGITS-1:0]   dp_s;
  logic [NUM_DIGITS-1:0]   blank_s;

  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blank;
  logic                  lit;
  logic                  on;
  logic [6:0]            seg_n;
  logic                  dp_n;
  logic [NUM_DIGITS-1:0] an_n;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Loop select keeps unused index codes (non power-of-two counts) dark.
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (32'(digit_idx) == k) begin
        cur_nib   = data_s[4*k +: 4];
        cur_dp    = dp_s[k];
        cur_blank = blank_s[k];
      end
    end
  end

  always_comb begin
    lit   = (p[DIV_BITS-1 -: BRIGHT_BITS] < brightness);
    on    = lit & ~cur_blank;
    an_n  = '1;
    seg_n = 7'h7F;
    dp_n  = 1'b1;
    if (on) begin
      seg_n = hex7(cur_nib);
      dp_n  = ~cur_dp;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (32'(digit_idx) == k) an_n[k] = 1'b0;
      end
    end
  end

  // Outputs are computed from the pre-edge digit/snapshot, so a load on an
  // advance edge first appears together with the new digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p         <= '0;
      digit_idx <= '0;
      data_s    <= '0;
      dp_s      <= '0;
      blank_s   <= '0;
      seg       <= 7'h7F;
      dp        <= 1'b1;
      an        <= '1;
    end else begin
      p <= p + 1'b1;
      if (p == '1) begin
        if (digit_idx == IDX_W'(NUM_DIGITS - 1)) digit_idx <= '0;
        else                                     digit_idx <= digit_idx + 1'b1;
      end
      if (load) begin
        data_s  <= data;
        dp_s    <= dp_in;
        blank_s <= blank;
      end
      seg <= seg_n;
      dp  <= dp_n;
      an  <= an_n;
    end
  end

  a_no_phantom_anode: assert property (@(posedge clk) disable iff (!rst_n)
    !((an != '1) && (32'(digit_idx) >= NUM_DIGITS)));

endmodule
